fetch_stage: RTL and testbench

//  IF stage of the 5-stage RISC pipeline: owns the PC, issues word reads to instruction

---
 rtl/pipeline_pkg.sv | 18 +
 rtl/fetch_stage_if.sv | 24 ++
 rtl/fetch_queue.sv | 53 +++++
 rtl/fetch_stage.sv | 122 ++++++++++++
 tb/tb_fetch_stage.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared constants and types for the RISC pipeline front end.
package pipeline_pkg;

  localparam logic [31:0] NOP_IR = 32'h0000_0000;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  // EX-stage next-PC select encodings
  localparam logic [1:0] CS_SEQ  = 2'b00;
  localparam logic [1:0] CS_BRA  = 2'b01;
  localparam logic [1:0] CS_RAA  = 2'b10;
  localparam logic [1:0] CS_BRA2 = 2'b11;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface fetch_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO buffering fetched words; flush beats push, push+pop on full allowed.
module fetch_queue
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);
  localparam int            AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  fetch_entry_t  slot_reg [DEPTH];
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign count   = count_reg;
  assign head    = slot_reg[rd_ptr_reg];
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= (wr_ptr_reg == LAST) ? '0 : wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= (rd_ptr_reg == LAST) ? '0 : rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  // Payload storage carries no reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) slot_reg[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues word fetches, buffers returns and drives the IF/ID register.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int          FQ_DEPTH = 2,
  parameter logic [31:0] NOP_IR   = pipeline_pkg::NOP_IR,
  parameter logic [31:0] RST_PC   = pipeline_pkg::RST_PC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           c_select,
  input  logic [31:0]          bra,
  input  logic [31:0]          raa,
  input  logic                 id_stall,
  fetch_stage_if.master        imem,
  output logic                 id_valid,
  output logic [31:0]          id_ir,
  output logic [31:0]          id_pc
);
  localparam int          CW  = $clog2(FQ_DEPTH + 1);
  localparam logic [CW:0] CAP = (CW + 1)'(FQ_DEPTH);

  logic [31:0]   pc_reg;
  logic [31:0]   rsp_pc_reg;
  logic [CW-1:0] outstanding_reg;
  logic [CW-1:0] drop_cnt_reg;
  logic          id_valid_reg;
  logic [31:0]   id_ir_reg;
  logic [31:0]   id_pc_reg;

  logic          redirect;
  logic [31:0]   target;
  logic [CW:0]   in_use;
  logic          req_valid;
  logic          fire;
  logic          rsp_valid;
  logic          q_push;
  logic          q_pop;
  logic          q_empty;
  logic          q_full;
  logic [CW-1:0] q_count;
  fetch_entry_t  q_head;
  fetch_entry_t  q_in;

  assign redirect  = (c_select != CS_SEQ);
  assign target    = (c_select == CS_RAA) ? raa : bra;
  assign rsp_valid = imem.imem_rsp_valid;

  // Words in flight plus words buffered never exceed the queue size, so a push never overflows.
  assign in_use    = {1'b0, outstanding_reg} + {1'b0, q_count};
  assign req_valid = rst_n && !redirect && (in_use < CAP);
  assign fire      = req_valid && imem.imem_req_ready;

  assign imem.imem_req_valid = req_valid;
  assign imem.imem_addr      = pc_reg;

  assign q_push = rsp_valid && !redirect && (drop_cnt_reg == '0);
  assign q_pop  = !id_stall && !q_empty && !redirect;
  assign q_in   = '{pc: rsp_pc_reg, ir: imem.imem_rsp_data};

  fetch_queue #(
    .DEPTH (FQ_DEPTH),
    .CW    (CW)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (q_push),
    .push_data (q_in),
    .pop       (q_pop),
    .head      (q_head),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg          <= RST_PC;
      rsp_pc_reg      <= RST_PC;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
      id_valid_reg    <= 1'b0;
      id_ir_reg       <= NOP_IR;
      id_pc_reg       <= '0;
    end else begin
      outstanding_reg <= outstanding_reg + CW'(fire) - CW'(rsp_valid);
      if (redirect) begin
        // Everything still in flight belongs to the old path; the word arriving now is dropped too.
        pc_reg       <= target;
        rsp_pc_reg   <= target;
        drop_cnt_reg <= outstanding_reg - CW'(rsp_valid);
        id_valid_reg <= 1'b0;
        id_ir_reg    <= NOP_IR;
      end else begin
        if (fire) pc_reg <= pc_reg + 32'd1;
        if (rsp_valid) begin
          if (drop_cnt_reg != '0) drop_cnt_reg <= drop_cnt_reg - 1'b1;
          else                    rsp_pc_reg   <= rsp_pc_reg + 32'd1;
        end
        if (!id_stall) begin
          if (!q_empty) begin
            id_valid_reg <= 1'b1;
            id_ir_reg    <= q_head.ir;
            id_pc_reg    <= q_head.pc;
          end else begin
            id_valid_reg <= 1'b0;
            id_ir_reg    <= NOP_IR;
          end
        end
      end
    end
  end

  assign id_valid = id_valid_reg;
  assign id_ir    = id_ir_reg;
  assign id_pc    = id_pc_reg;

  logic unused_ok;
  assign unused_ok = q_full;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage: program-order reference stream vs IF/ID output.
module tb_fetch_stage;
  localparam int          FQ_DEPTH   = 2;
  localparam logic [31:0] EXP_NOP    = 32'h0000_0000;
  localparam logic [31:0] EXP_RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  c_select;
  logic [31:0] bra;
  logic [31:0] raa;
  logic        id_stall;
  logic        id_valid;
  logic [31:0] id_ir;
  logic [31:0] id_pc;

  always #5 clk = ~clk;

  fetch_stage_if imem_bus ();

  fetch_stage #(
    .FQ_DEPTH (FQ_DEPTH),
    .NOP_IR   (EXP_NOP),
    .RST_PC   (EXP_RST_PC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .c_select (c_select),
    .bra      (bra),
    .raa      (raa),
    .id_stall (id_stall),
    .imem     (imem_bus),
    .id_valid (id_valid),
    .id_ir    (id_ir),
    .id_pc    (id_pc)
  );

  typedef struct { logic [31:0] pc; logic [31:0] ir; } word_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  word_t       exp_q[$];
  pend_t       pend_q[$];
  logic [31:0] path_next   = EXP_RST_PC;
  logic [31:0] exp_fetch   = EXP_RST_PC;
  logic [31:0] last_id_pc  = '0;
  logic [31:0] prev_addr   = '0;
  logic        prev_hold   = 1'b0;
  int          cyc         = 0;
  int          lat_max     = 1;
  int          n_checks    = 0;
  int          n_fail      = 0;
  int          n_valid     = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check the issue side before the edge, model memory after it.
  task automatic tick(input logic r, input logic [1:0] cs, input logic [31:0] b,
                      input logic [31:0] ra, input logic st, input logic rdy);
    logic        pv, rv, fire, redir;
    logic [31:0] pa, tgt;
    rst_n = r; c_select = cs; bra = b; raa = ra; id_stall = st;
    imem_bus.imem_req_ready = rdy;
    redir = r && (cs != 2'b00);
    tgt   = (cs == 2'b10) ? ra : b;
    if (!r) begin
      exp_q.delete(); path_next = EXP_RST_PC;
    end else if (redir) begin
      exp_q.delete(); path_next = tgt;
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back('{pc: path_next, ir: mem_word(path_next)});
      path_next = path_next + 32'd1;
    end
    #3;
    pv   = imem_bus.imem_req_valid;
    pa   = imem_bus.imem_addr;
    rv   = imem_bus.imem_rsp_valid;
    fire = pv && rdy;
    if (r && prev_hold) begin
      chk("addr_hold", pa, prev_addr);
      if (!redir) chk("valid_hold", 32'(pv), 32'd1);
    end
    if (redir) chk("no_issue_on_redirect", 32'(pv), 32'd0);
    else if (r && fire) chk("fetch_addr", pa, exp_fetch);
    prev_hold = r && pv && !rdy && !redir;
    prev_addr = pa;
    @(posedge clk);
    cyc++;
    if (!r) begin
      pend_q.delete();
      exp_fetch = EXP_RST_PC;
    end else begin
      if (rv && pend_q.size() > 0) void'(pend_q.pop_front());
      if (fire) pend_q.push_back('{addr: pa, due: cyc + $urandom_range(1, lat_max) - 1});
      if (redir)     exp_fetch = tgt;
      else if (fire) exp_fetch = exp_fetch + 32'd1;
    end
    chk("in_flight_cap", 32'(pend_q.size() <= FQ_DEPTH), 32'd1);
    @(negedge clk);
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_bus.imem_rsp_valid = 1'b1;
      imem_bus.imem_rsp_data  = mem_word(pend_q[0].addr);
    end else begin
      imem_bus.imem_rsp_valid = 1'b0;
      imem_bus.imem_rsp_data  = $urandom;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  // Monitor: compares the IF/ID register against the reference stream after every edge.
  initial begin
    logic        s_rst, s_redir, s_stall;
    logic [31:0] s_tgt, p_ir, p_pc;
    logic        p_v;
    word_t       w;
    p_v = 1'b0; p_ir = '0; p_pc = '0;
    forever begin
      @(posedge clk);
      s_rst   = rst_n;
      s_redir = rst_n && (c_select != 2'b00);
      s_stall = id_stall;
      s_tgt   = (c_select == 2'b10) ? raa : bra;
      #1;
      if (!s_rst) begin
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_id_ir", id_ir, EXP_NOP);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_req_valid", 32'(imem_bus.imem_req_valid), 32'd0);
      end else if (s_redir) begin
        chk("redir_id_valid", 32'(id_valid), 32'd0);
        chk("redir_id_ir", id_ir, EXP_NOP);
        chk("redir_addr", imem_bus.imem_addr, s_tgt);
      end else if (s_stall) begin
        chk("stall_valid", 32'(id_valid), 32'(p_v));
        chk("stall_ir", id_ir, p_ir);
        chk("stall_pc", id_pc, p_pc);
      end else if (id_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL id_word: got unexpected pc %h required none", id_pc);
        end else begin
          w = exp_q.pop_front();
          chk("id_pc", id_pc, w.pc);
          chk("id_ir", id_ir, w.ir);
          n_valid++;
          last_id_pc = id_pc;
          $display("id word pc=%h ir=%h", id_pc, id_ir);
        end
      end else begin
        chk("bubble_ir", id_ir, EXP_NOP);
        chk("bubble_pc_hold", id_pc, p_pc);
      end
      p_v = id_valid; p_ir = id_ir; p_pc = id_pc;
    end
  end

  initial begin
    int first, nv0, waited;
    imem_bus.imem_rsp_valid = 1'b0;
    imem_bus.imem_rsp_data  = '0;
    tick(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    tick(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);

    // Sequential stream, 1-cycle memory
    lat_max = 1; first = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
      if (id_valid && first == 0) first = i;
    end
    chk("first_valid_cycle", 32'(first >= 1 && first <= 3), 32'd1);
    run(20);

    // Decoder stall mid-stream
    repeat (5) tick(1'b1, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1);
    run(10);

    // Branch with two words in flight
    lat_max = 3; waited = 0;
    while (pend_q.size() != 2 && waited < 50) begin run(1); waited++; end
    chk("t3_two_in_flight", 32'(pend_q.size()), 32'd2);
    nv0 = n_valid;
    tick(1'b1, 2'b01, 32'h0000_0040, 32'h0, 1'b0, 1'b1);
    run(15);
    chk("t3_resumed", 32'(n_valid > nv0), 32'd1);

    // Register jump coinciding with a response and a stall
    waited = 0;
    while (!imem_bus.imem_rsp_valid && waited < 50) begin run(1); waited++; end
    chk("t4_rsp_present", 32'(imem_bus.imem_rsp_valid), 32'd1);
    nv0 = n_valid;
    tick(1'b1, 2'b10, 32'h0, 32'h0000_0100, 1'b1, 1'b1);
    run(15);
    chk("t4_resumed", 32'(n_valid > nv0), 32'd1);

    // Memory not ready
    lat_max = 1;
    repeat (4) tick(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    run(10);

    // Alternate branch encoding
    tick(1'b1, 2'b11, 32'h0000_2000, 32'h0000_3000, 1'b0, 1'b1);
    run(10);
    chk("cs11_target_path", 32'(last_id_pc >= 32'h2000 && last_id_pc < 32'h2010), 32'd1);

    // PC wrap-around, then reset mid-stream
    tick(1'b1, 2'b01, 32'hFFFF_FFFE, 32'h0, 1'b0, 1'b1);
    run(10);
    chk("wrap_id_pc", 32'(last_id_pc < 32'h10), 32'd1);
    tick(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    run(12);
    chk("restart_id_pc", 32'(last_id_pc < 32'h10), 32'd1);

    // Randomized traffic
    lat_max = 3;
    for (int i = 0; i < 2000; i++) begin
      logic        r, st, rdy;
      logic [1:0]  cs;
      logic [31:0] b, ra;
      r   = ($urandom % 500) != 0;
      cs  = (($urandom % 20) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      b   = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 + ($urandom % 16)) : $urandom;
      ra  = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 + ($urandom % 16)) : $urandom;
      st  = ($urandom % 4) == 0;
      rdy = ($urandom % 4) != 0;
      tick(r, cs, b, ra, st, rdy);
    end
    run(10);
    chk("progress", 32'(n_valid > 200), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
